// File: rtl/sdr_tx_arbiter.sv
// sdr_tx_arbiter: packet scheduler for the Ethernet transmit path.
// Issues one registered grant at a time (RESP > CC > MIC > WB > DDC round-robin),
// holds it until the sender pulses done, paces wideband blocks against DDC
// round-robin wraps, and drops a grant that stays stuck while run is low.
`timescale 1ns/1ps

module sdr_tx_arbiter #(
  parameter int NR      = 8,
  parameter int TIMEOUT = 250000000
) (
  input  logic          tx_clock,
  input  logic          reset,
  input  logic          run,
  input  logic          wideband,
  input  logic [7:0]    wb_packets_per_frame,
  input  logic          resp_req,
  input  logic          CC_data_ready,
  input  logic          mic_fifo_ready,
  input  logic          sp_data_ready,
  input  logic [NR-1:0] fifo_ready,
  input  logic          done,
  output logic          grant_valid,
  output logic [2:0]    grant_type,
  output logic [7:0]    grant_port,
  output logic [7:0]    port_ID,
  output logic          wb_last,
  output logic          phy_ready,
  output logic          timeout
);

  // Watchdog only ever holds 0..TIMEOUT-1; it fires on the cycle it would reach TIMEOUT.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  typedef enum logic [2:0] {
    GT_NONE = 3'd0,
    GT_RESP = 3'd1,
    GT_CC   = 3'd2,
    GT_MIC  = 3'd3,
    GT_WB   = 3'd4,
    GT_DDC  = 3'd5
  } gtype_e;

  state_e            state_q, state_d;
  logic              grant_valid_q, grant_valid_d;
  gtype_e            grant_type_q, grant_type_d;
  logic [7:0]        grant_port_q, grant_port_d;
  logic [7:0]        port_id_q, port_id_d;
  logic              wb_last_q, wb_last_d;
  logic              timeout_q, timeout_d;
  logic [2:0]        rr_q, rr_d;
  logic              wb_active_q, wb_active_d;
  logic [7:0]        wb_count_q, wb_count_d;
  logic              wb_pending_q, wb_pending_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  // Request decode results
  gtype_e            sel_type;
  logic              sel_wb_start;
  logic              sel_wb_cont;
  logic              ddc_hit;
  logic [2:0]        ddc_idx;
  logic [2:0]        ddc_rr_next;
  logic              ddc_wrap;
  logic [7:0]        wb_len;
  logic [7:0]        ready8;
  logic              wd_fire;

  // Round-robin search: first ready DDC at or above rr, wrapping modulo NR.
  always_comb begin
    logic [3:0] cand;
    logic [3:0] nxt;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cand        = '0;
    nxt         = '0;
    ddc_hit     = 1'b0;
    ddc_idx     = '0;
    ready8      = 8'(fifo_ready);
    for (int i = 0; i < NR; i++) begin
      cand = {1'b0, rr_q} + 4'(i);
      if (cand >= 4'(NR)) cand = cand - 4'(NR);
      if (!ddc_hit && ready8[cand[2:0]]) begin
        ddc_hit = 1'b1;
        ddc_idx = cand[2:0];
      end
    end
    nxt         = {1'b0, ddc_idx} + 4'd1;
    ddc_wrap    = (nxt == 4'(NR));
    ddc_rr_next = ddc_wrap ? 3'd0 : nxt[2:0];
  end

  // Fixed-priority request selection, evaluated every cycle and used only in IDLE.
  always_comb begin
    sel_type     = GT_NONE;
    sel_wb_start = 1'b0;
    sel_wb_cont  = 1'b0;
    wb_len       = (wb_packets_per_frame == 8'd0) ? 8'd1 : wb_packets_per_frame;
    wd_fire      = (state_q == S_BUSY) && !run && (wd_q == WD_W'(TIMEOUT - 1));
    if (resp_req) begin
      sel_type = GT_RESP;
    end else if (run && CC_data_ready) begin
      sel_type = GT_CC;
    end else if (run && mic_fifo_ready) begin
      sel_type = GT_MIC;
    end else if (run && wideband && sp_data_ready && !wb_active_q) begin
      sel_type     = GT_WB;
      sel_wb_start = 1'b1;
    end else if (run && wb_pending_q && sp_data_ready) begin
      sel_type    = GT_WB;
      sel_wb_cont = 1'b1;
    end else if (run && ddc_hit) begin
      sel_type = GT_DDC;
    end
  end

  // Next-state logic: IDLE grants on any request, BUSY leaves on done or watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (sel_type != GT_NONE) state_d = S_BUSY;
      S_BUSY: if (done || wd_fire)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant outputs, wideband pacing, round-robin pointer and watchdog updates.
  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_type_d  = grant_type_q;
    grant_port_d  = grant_port_q;
    port_id_d     = port_id_q;
    wb_last_d     = wb_last_q;
    timeout_d     = 1'b0;
    rr_d          = rr_q;
    wb_active_d   = wb_active_q;
    wb_count_d    = wb_count_q;
    wb_pending_d  = wb_pending_q;
    wd_d          = wd_q;

    case (state_q)
      S_IDLE: begin
        if (!run) begin
          rr_d         = '0;
          wb_active_d  = 1'b0;
          wb_count_d   = '0;
          wb_pending_d = 1'b0;
        end
        if (sel_type != GT_NONE) begin
          grant_valid_d = 1'b1;
          grant_type_d  = sel_type;
          grant_port_d  = 8'd0;
          wb_last_d     = 1'b0;
          wd_d          = '0;
          case (sel_type)
            GT_RESP: port_id_d = 8'd0;
            GT_CC:   port_id_d = 8'd1;
            GT_MIC:  port_id_d = 8'd2;
            GT_WB: begin
              port_id_d = 8'd3;
              if (sel_wb_start) begin
                wb_active_d = 1'b1;
                wb_count_d  = 8'd1;
                wb_last_d   = (wb_len == 8'd1);
              end else begin
                wb_count_d   = wb_count_q + 8'd1;
                wb_pending_d = 1'b0;
                wb_last_d    = ((wb_count_q + 8'd1) == wb_len);
              end
            end
            GT_DDC: begin
              grant_port_d = {5'd0, ddc_idx};
              port_id_d    = 8'd11 + {5'd0, ddc_idx};
              rr_d         = ddc_rr_next;
              if (ddc_wrap && wb_active_q) wb_pending_d = 1'b1;
            end
            default: port_id_d = 8'd0;
          endcase
        end else if (run && wb_active_q) begin
          // Idle cycle with nothing to send also counts as a round-robin wrap.
          wb_pending_d = 1'b1;
        end
      end

      S_BUSY: begin
        wd_d = run ? '0 : wd_q + 1'b1;
        if (done || wd_fire) begin
          if (done && grant_type_q == GT_WB && wb_last_q) begin
            wb_active_d  = 1'b0;
            wb_count_d   = '0;
            wb_pending_d = 1'b0;
          end
          timeout_d     = !done;
          wd_d          = '0;
          grant_valid_d = 1'b0;
          grant_type_d  = GT_NONE;
          grant_port_d  = 8'd0;
          port_id_d     = 8'd0;
          wb_last_d     = 1'b0;
        end
      end

      default: ;
    endcase

    if (!wideband) begin
      wb_active_d  = 1'b0;
      wb_count_d   = '0;
      wb_pending_d = 1'b0;
    end
  end

  // State and output registers; reset drops any held grant immediately.
  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_valid_q <= 1'b0;
      grant_type_q  <= GT_NONE;
      grant_port_q  <= '0;
      port_id_q     <= '0;
      wb_last_q     <= 1'b0;
      timeout_q     <= 1'b0;
      rr_q          <= '0;
      wb_active_q   <= 1'b0;
      wb_count_q    <= '0;
      wb_pending_q  <= 1'b0;
      wd_q          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_type_q  <= grant_type_d;
      grant_port_q  <= grant_port_d;
      port_id_q     <= port_id_d;
      wb_last_q     <= wb_last_d;
      timeout_q     <= timeout_d;
      rr_q          <= rr_d;
      wb_active_q   <= wb_active_d;
      wb_count_q    <= wb_count_d;
      wb_pending_q  <= wb_pending_d;
      wd_q          <= wd_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_type  = grant_type_q;
  assign grant_port  = grant_port_q;
  assign port_ID     = port_id_q;
  assign wb_last     = wb_last_q;
  assign timeout     = timeout_q;
  assign phy_ready   = !((state_q == S_BUSY) && (grant_type_q == GT_DDC)) && !fifo_ready[0];

endmodule

// File: tb/tb_sdr_tx_arbiter.sv
// Testbench for sdr_tx_arbiter: table-driven grant sequences plus hand-written
// sequences for run-low behaviour, watchdog timeout and asynchronous reset.
`timescale 1ns/1ps

module tb_sdr_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic          tx_clock = 1'b0;
  logic          reset;
  logic          run;
  logic          wideband;
  logic [7:0]    wb_packets_per_frame;
  logic          resp_req;
  logic          CC_data_ready;
  logic          mic_fifo_ready;
  logic          sp_data_ready;
  logic [NR-1:0] fifo_ready;
  logic          done;
  logic          grant_valid;
  logic [2:0]    grant_type;
  logic [7:0]    grant_port;
  logic [7:0]    port_ID;
  logic          wb_last;
  logic          phy_ready;
  logic          timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       run;
    logic       wb;
    logic       resp;
    logic       cc;
    logic       mic;
    logic       sp;
    logic [7:0] ppf;
    logic [3:0] fifo;
    logic [2:0] t;
    logic [7:0] port;
    logic [7:0] pid;
    logic       last;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  sdr_tx_arbiter #(.NR(NR), .TIMEOUT(TO)) dut (
    .tx_clock             (tx_clock),
    .reset                (reset),
    .run                  (run),
    .wideband             (wideband),
    .wb_packets_per_frame (wb_packets_per_frame),
    .resp_req             (resp_req),
    .CC_data_ready        (CC_data_ready),
    .mic_fifo_ready       (mic_fifo_ready),
    .sp_data_ready        (sp_data_ready),
    .fifo_ready           (fifo_ready),
    .done                 (done),
    .grant_valid          (grant_valid),
    .grant_type           (grant_type),
    .grant_port           (grant_port),
    .port_ID              (port_ID),
    .wb_last              (wb_last),
    .phy_ready            (phy_ready),
    .timeout              (timeout)
  );

  always #5 tx_clock = ~tx_clock;

  task automatic step();
    @(posedge tx_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic rq, input logic c,
                              input logic m, input logic s, input logic [7:0] ppf,
                              input logic [3:0] f, input logic [2:0] t, input logic [7:0] port,
                              input logic [7:0] pid, input logic last);
    vec_t v;
    v.run = r; v.wb = w; v.resp = rq; v.cc = c; v.mic = m; v.sp = s;
    v.ppf = ppf; v.fifo = f; v.t = t; v.port = port; v.pid = pid; v.last = last;
    return v;
  endfunction

  // Present one request set in IDLE, check the grant one edge later, hold it,
  // pulse done three cycles after the grant and check that it drops.
  task automatic apply_row(input string tag, input vec_t v);
    logic exp_phy;
    run = v.run; wideband = v.wb; resp_req = v.resp; CC_data_ready = v.cc;
    mic_fifo_ready = v.mic; sp_data_ready = v.sp; wb_packets_per_frame = v.ppf;
    fifo_ready = v.fifo;
    exp_phy = (v.t == 3'd5) ? 1'b0 : ~v.fifo[0];
    step();
    check({tag, " valid"},   32'(grant_valid), 32'(1));
    check({tag, " type"},    32'(grant_type),  32'(v.t));
    check({tag, " port"},    32'(grant_port),  32'(v.port));
    check({tag, " port_ID"}, 32'(port_ID),     32'(v.pid));
    check({tag, " wb_last"}, 32'(wb_last),     32'(v.last));
    check({tag, " phy"},     32'(phy_ready),   32'(exp_phy));
    step();
    step();
    check({tag, " hold valid"}, 32'(grant_valid), 32'(1));
    check({tag, " hold pid"},   32'(port_ID),     32'(v.pid));
    done = 1'b1;
    step();
    done = 1'b0;
    check({tag, " drop valid"}, 32'(grant_valid), 32'(0));
    check({tag, " drop type"},  32'(grant_type),  32'(0));
    check({tag, " drop tmo"},   32'(timeout),     32'(0));
    resp_req = 1'b0; CC_data_ready = 1'b0; mic_fifo_ready = 1'b0;
    sp_data_ready = 1'b0; fifo_ready = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Round-robin over four DDCs, then priority RESP > CC > MIC > DDC.
    tbl_a.push_back(mk(Y,N,N,N,N,N,8'd0,4'hF,3'd5,8'd0,8'd11,N));
    tbl_a.push_back(mk(Y,N,N,N,N,N,8'd0,4'hF,3'd5,8'd1,8'd12,N));
    tbl_a.push_back(mk(Y,N,N,N,N,N,8'd0,4'hF,3'd5,8'd2,8'd13,N));
    tbl_a.push_back(mk(Y,N,N,N,N,N,8'd0,4'hF,3'd5,8'd3,8'd14,N));
    tbl_a.push_back(mk(Y,N,N,N,N,N,8'd0,4'hF,3'd5,8'd0,8'd11,N));
    tbl_a.push_back(mk(Y,N,Y,Y,Y,N,8'd0,4'h4,3'd1,8'd0,8'd0,N));
    tbl_a.push_back(mk(Y,N,N,Y,Y,N,8'd0,4'h4,3'd2,8'd0,8'd1,N));
    tbl_a.push_back(mk(Y,N,N,N,Y,N,8'd0,4'h4,3'd3,8'd0,8'd2,N));
    tbl_a.push_back(mk(Y,N,N,N,N,N,8'd0,4'h4,3'd5,8'd2,8'd13,N));

    // Wideband block of 3 interleaved with full DDC rounds.
    tbl_b.push_back(mk(Y,Y,N,N,N,Y,8'd3,4'hF,3'd4,8'd0,8'd3,N));
    for (int i = 0; i < 4; i++) tbl_b.push_back(mk(Y,Y,N,N,N,Y,8'd3,4'hF,3'd5,8'(i),8'(11+i),N));
    tbl_b.push_back(mk(Y,Y,N,N,N,Y,8'd3,4'hF,3'd4,8'd0,8'd3,N));
    for (int i = 0; i < 4; i++) tbl_b.push_back(mk(Y,Y,N,N,N,Y,8'd3,4'hF,3'd5,8'(i),8'(11+i),N));
    tbl_b.push_back(mk(Y,Y,N,N,N,Y,8'd3,4'hF,3'd4,8'd0,8'd3,Y));
    for (int i = 0; i < 4; i++) tbl_b.push_back(mk(Y,Y,N,N,N,N,8'd3,4'hF,3'd5,8'(i),8'(11+i),N));
    tbl_b.push_back(mk(Y,Y,N,N,N,Y,8'd3,4'hF,3'd4,8'd0,8'd3,N));
    // wideband low clears the block; packets_per_frame 0 acts as a block of 1.
    tbl_b.push_back(mk(Y,N,N,N,N,Y,8'd0,4'hF,3'd5,8'd0,8'd11,N));
    tbl_b.push_back(mk(Y,Y,N,N,N,Y,8'd0,4'hF,3'd4,8'd0,8'd3,Y));
    tbl_b.push_back(mk(Y,N,N,N,N,N,8'd0,4'h1,3'd5,8'd0,8'd11,N));

    reset = 1'b1; run = 1'b0; wideband = 1'b0; wb_packets_per_frame = 8'd0;
    resp_req = 1'b0; CC_data_ready = 1'b0; mic_fifo_ready = 1'b0;
    sp_data_ready = 1'b0; fifo_ready = '0; done = 1'b0;
    step();
    step();
    check("reset valid",   32'(grant_valid), 32'(0));
    check("reset type",    32'(grant_type),  32'(0));
    check("reset port",    32'(grant_port),  32'(0));
    check("reset port_ID", 32'(port_ID),     32'(0));
    check("reset wb_last", 32'(wb_last),     32'(0));
    check("reset timeout", 32'(timeout),     32'(0));
    check("reset phy",     32'(phy_ready),   32'(1));
    reset = 1'b0;
    step();

    foreach (tbl_a[i]) apply_row($sformatf("A%0d", i), tbl_a[i]);

    // run low: RESP still granted, CC ignored, done in IDLE ignored.
    run = 1'b0; resp_req = 1'b1;
    step();
    check("runlow resp valid", 32'(grant_valid), 32'(1));
    check("runlow resp type",  32'(grant_type),  32'(1));
    check("runlow resp pid",   32'(port_ID),     32'(0));
    resp_req = 1'b0;
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("runlow resp drop", 32'(grant_valid), 32'(0));
    CC_data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("runlow cc none %0d", i), 32'(grant_valid), 32'(0));
    end
    CC_data_ready = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    check("idle done ignored", 32'(grant_valid), 32'(0));
    step();
    check("idle done no tmo", 32'(timeout), 32'(0));

    foreach (tbl_b[i]) apply_row($sformatf("B%0d", i), tbl_b[i]);

    // Watchdog: hold a DDC grant, drop run, expect timeout TO edges later.
    run = 1'b1; fifo_ready = 4'b0001;
    step();
    check("wd grant type", 32'(grant_type), 32'(5));
    check("wd grant pid",  32'(port_ID),    32'(11));
    check("wd phy busy",   32'(phy_ready),  32'(0));
    fifo_ready = '0;
    step();
    check("wd phy ddc held", 32'(phy_ready),   32'(0));
    check("wd still held",   32'(grant_valid), 32'(1));
    run = 1'b0;
    for (int i = 1; i < TO; i++) begin
      step();
      check($sformatf("wd pre %0d tmo", i),   32'(timeout),     32'(0));
      check($sformatf("wd pre %0d valid", i), 32'(grant_valid), 32'(1));
    end
    step();
    check("wd fire tmo",   32'(timeout),     32'(1));
    check("wd fire valid", 32'(grant_valid), 32'(0));
    check("wd fire type",  32'(grant_type),  32'(0));
    check("wd fire phy",   32'(phy_ready),   32'(1));
    step();
    check("wd pulse end", 32'(timeout), 32'(0));

    // Asynchronous reset mid-grant, then round-robin restarts at index 0.
    run = 1'b1; fifo_ready = 4'hF;
    step();
    check("rst pre g0 port", 32'(grant_port), 32'(0));
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    check("rst pre g1 valid", 32'(grant_valid), 32'(1));
    check("rst pre g1 port",  32'(grant_port),  32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("rst async valid", 32'(grant_valid), 32'(0));
    check("rst async type",  32'(grant_type),  32'(0));
    check("rst async port",  32'(grant_port),  32'(0));
    check("rst async pid",   32'(port_ID),     32'(0));
    check("rst async phy",   32'(phy_ready),   32'(0));
    step();
    reset = 1'b0;
    step();
    check("rst post valid", 32'(grant_valid), 32'(1));
    check("rst post port",  32'(grant_port),  32'(0));
    check("rst post pid",   32'(port_ID),     32'(11));
    fifo_ready = '0;
    done = 1'b1;
    step();
    done = 1'b0;
    check("rst post drop", 32'(grant_valid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdr_tx_arbiter.md
# sdr_tx_arbiter

Packet scheduler for the Ethernet transmit path. It decides which source owns the UDP transmitter next: protocol responses, C&C status, mic audio, wideband spectrum, or one of NR DDC receive streams. It issues one registered grant at a time to the packet sender and holds it until the sender pulses `done`. It also runs the wideband block pacing, the DDC round-robin, the stuck-grant watchdog and the `phy_ready` status used for PureSignal/diversity mode changes.

## Interface
Parameters:
- `NR`, 8: number of DDC receivers, 1..8.
- `TIMEOUT`, 250000000: number of `tx_clock` cycles a grant may stay held while `run` is low before it is forcibly dropped.

Ports:
- `tx_clock`  in  1  transmit clock. All logic runs on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  host run enable.
- `wideband`  in  1  wideband spectrum enable.
- `wb_packets_per_frame`  in  8  wideband packets per block.
- `resp_req`  in  1  discovery, erase-done or send-more reply pending.
- `CC_data_ready`  in  1  C&C packet pending.
- `mic_fifo_ready`  in  1  mic packet available.
- `sp_data_ready`  in  1  wideband packet available.
- `fifo_ready`  in  NR  per-DDC packet available.
- `done`  in  1  one-cycle pulse from the sender: granted packet finished.
- `grant_valid`  out  1  grant held.
- `grant_type`  out  3  0 none, 1 RESP, 2 CC, 3 MIC, 4 WB, 5 DDC.
- `grant_port`  out  8  DDC index when `grant_type` is 5, else 0.
- `port_ID`  out  8  from-port offset: 0 RESP, 1 CC, 2 MIC, 3 WB, 11+index for DDC.
- `wb_last`  out  1  the current WB grant is the last packet of its block.
- `phy_ready`  out  1  no DDC grant held and `fifo_ready[0]` is low.
- `timeout`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- State machine has two states, IDLE and BUSY. Reset puts it in IDLE with every registered output at 0. Internal state also resets: `rr`=0, `wb_active`=0, `wb_count`=0, `wb_pending`=0, watchdog=0.
- In IDLE the arbiter evaluates requests in a fixed priority order. The first match registers `grant_*`, `port_ID` and `grant_valid`=1, and the state moves to BUSY.
  - 1. RESP, whenever `resp_req` is high. This is granted even when `run` is low.
  - 2. CC: `run & CC_data_ready`.
  - 3. MIC: `run & mic_fifo_ready`.
  - 4. WB start: `run & wideband & sp_data_ready & !wb_active`. Sets `wb_active`=1 and `wb_count`=1.
  - 5. WB continue: `run & wb_pending & sp_data_ready`. Increments `wb_count` and clears `wb_pending`.
  - 6. DDC: `run` and any `fifo_ready` bit high. Grants the first ready index searching upward from `rr`, modulo NR. Then `rr` is set to (granted+1) mod NR.
- Wrap event: a DDC grant at index NR-1, or an IDLE cycle with `run` high and no request at all. A wrap event with `wb_active` high sets `wb_pending`.
- WB block length is L = max(`wb_packets_per_frame`, 1). `wb_last` = (`wb_count` == L) at grant time. When that grant's `done` arrives, `wb_active`, `wb_count` and `wb_pending` all clear.
- `wideband` low clears `wb_active`, `wb_count` and `wb_pending` every cycle. An in-flight WB grant is still held until its `done`.
- `run` low in IDLE resets `rr`, `wb_active`, `wb_count` and `wb_pending`.
- In BUSY:
  - `done` moves the state to IDLE and drops all grant outputs.
  - Request inputs are ignored.
  - `done` in IDLE is ignored.
- Watchdog counts BUSY cycles while `run` is low. It clears on entry to BUSY and whenever `run` is high. When it reaches TIMEOUT, the state forces to IDLE, grants drop and `timeout` pulses.
- `phy_ready` is combinational: !(BUSY & `grant_type`==5) & !`fifo_ready[0]`.

## Timing
- The request is sampled at edge n. `grant_valid` and all grant fields are valid after edge n, and stay stable until the edge that samples `done`.
- `done` sampled at edge m: `grant_valid` is low after m, and the state is IDLE after m.
- The earliest next grant is after edge m+1. There is always at least one cycle of `grant_valid` low between grants.
- Asynchronous `reset` mid-grant clears `grant_valid` immediately, with no waiting for `done`.
- Watchdog: if `run` falls at edge k while BUSY, `timeout` pulses after edge k+TIMEOUT.

## Test plan
- NR=4, `run`=1, `fifo_ready`=4'b1111, `done` issued 3 cycles after each grant -> `grant_port` sequence 0,1,2,3,0; `port_ID` sequence 11,12,13,14,11.
- `resp_req`, `CC_data_ready`, `mic_fifo_ready` and `fifo_ready[2]` all high together -> grant order RESP, CC, MIC, DDC2; `port_ID` sequence 0,1,2,13.
- `wideband`=1, `wb_packets_per_frame`=3, `sp_data_ready`=1, all DDC ready -> WB(`wb_last`=0), DDC0..3, WB(0), DDC0..3, WB(`wb_last`=1), DDC0..3, then a new block starts with WB(0).
- `run`=0, `resp_req` pulse -> RESP granted. `CC_data_ready`=1 with `run`=0 -> no grant.
- TIMEOUT=16: hold a DDC grant without `done`, then drop `run` -> `timeout` pulses 16 cycles later, `grant_valid`=0, and `phy_ready`=1 with `fifo_ready[0]`=0.
- Assert `reset` while BUSY -> all outputs 0 asynchronously. After release, the first DDC grant is index 0.
